aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey (AES-128).
REQ-002 Parameter: ADDR_W, 4, round-key address width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_loaded  input  1  round-key store fully loaded; level signal.
REQ-006 din_valid  input  1  plaintext block present on the external data bus.
REQ-007 din_ready  output  1  controller accepts a block this cycle.
REQ-008 dout_valid  output  1  ciphertext in the state register is valid.
REQ-009 dout_ready  input  1  consumer takes the ciphertext this cycle.
REQ-010 rk_addr  output  ADDR_W  round-key address, 1..NUM_ROUNDS+1 when active, 0 = no key.
REQ-011 ld_state  output  1  state register loads din XOR round key (initial AddRoundKey).
REQ-012 rnd_en  output  1  state register loads SubBytes/ShiftRows/[MixColumns]/AddRoundKey result.
REQ-013 mix_en  output  1  MixColumns stage is included in this round.
REQ-014 busy  output  1  a block is in flight (LOAD, ROUND or FINAL).
REQ-015 abort  output  1  one-cycle pulse: an in-flight block was discarded.

Function
REQ-016 States: IDLE, LOAD, ROUND, FINAL, OUT, held in a registered state plus a round counter rnd_cnt of ADDR_W bits.
REQ-017 All outputs except abort are decoded combinationally from the registered state and rnd_cnt; abort is registered.
REQ-018 IDLE: din_ready = key_loaded; on din_valid & din_ready go to LOAD; otherwise stay.
REQ-019 LOAD (1 cycle): rk_addr = 1, ld_state = 1, busy = 1; next ROUND with rnd_cnt = 2.
REQ-020 ROUND: rk_addr = rnd_cnt, rnd_en = 1, mix_en = 1, busy = 1; rnd_cnt increments each cycle; when rnd_cnt = NUM_ROUNDS go to FINAL.
REQ-021 FINAL (1 cycle): rk_addr = NUM_ROUNDS+1, rnd_en = 1, mix_en = 0, busy = 1; next OUT.
REQ-022 OUT: dout_valid = 1 and held stable until dout_ready; din_ready = dout_ready & key_loaded.
REQ-023 OUT with dout_ready and no new input: go to IDLE; with dout_ready, din_valid and key_loaded: go directly to LOAD (back-to-back, no bubble).
REQ-024 Latency: input handshake at cycle T -> LOAD at T+1, rounds at T+2..T+NUM_ROUNDS, FINAL at T+NUM_ROUNDS+1, dout_valid from T+NUM_ROUNDS+2.
REQ-025 Throughput: one block per NUM_ROUNDS+2 cycles when the consumer is always ready.
REQ-026 key_loaded low in LOAD, ROUND or FINAL: next state IDLE, abort = 1 for one cycle, no dout_valid for that block.
REQ-027 key_loaded low in OUT: the completed block is still delivered, and no new block is accepted.
REQ-028 din_ready, ld_state, rnd_en and dout_valid shall never be asserted in the same cycle as rk_addr = 0, except din_ready and dout_valid in IDLE and OUT.
REQ-029 Unreachable state encodings shall return to IDLE.

Reset
REQ-030 rst_n low shall asynchronously force state = IDLE, rnd_cnt = 0 and abort = 0, giving rk_addr = 0, ld_state = rnd_en = mix_en = busy = dout_valid = 0.
REQ-031 Reset mid-block discards the block without an abort pulse; after rst_n rises, din_ready follows key_loaded.

Structure
REQ-032 The state encodings, NUM_ROUNDS default and rk_addr values (first = 1, last = NUM_ROUNDS+1) shall live in a shared aes_pkg, also used by the key-store sequencer.
REQ-033 A single sub-module, aes_round_counter (loadable, incrementing, with a terminal-count flag), is permitted; otherwise the block is flat.

Verification
REQ-034 Reset, key_loaded = 1, din_valid at cycle 0 -> rk_addr sequence 1,2,...,11 over cycles 1..11, mix_en = 0 only at rk_addr 11, dout_valid at cycle 12.
REQ-035 key_loaded = 0, din_valid = 1 -> din_ready = 0 and no activity for 20 cycles.
REQ-036 dout_ready low for 5 cycles in OUT -> dout_valid held, din_ready = 0, no state change.
REQ-037 dout_ready = 1 and a second din_valid in OUT -> LOAD on the next cycle, i.e. 12-cycle spacing between dout_valid pulses.
REQ-038 key_loaded dropped during rk_addr = 6 -> abort pulse next cycle, IDLE, no dout_valid.
REQ-039 rst_n asserted asynchronously during ROUND -> all outputs 0 immediately, clean restart afterwards.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES control definitions: controller state encoding, round count and
// round-key address map used by the round controller and the key-store sequencer.
package aes_pkg;

    localparam int NUM_ROUNDS_DEF = 10;
    localparam int RK_ADDR_W_DEF  = 4;

    // Key 0 is reserved as "no key"; key 1 feeds the initial AddRoundKey.
    localparam int RK_NONE  = 0;
    localparam int RK_FIRST = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    function automatic int rk_last(input int num_rounds);
        return num_rounds + 1;
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Loadable incrementing round counter with a terminal-count flag.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int W = RK_ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == term_val);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES iterative round controller: sequences LOAD, the middle rounds and the
// final round, drives round-key addresses and holds the result until consumed.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int ADDR_W     = RK_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_loaded,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ADDR_W-1:0] rk_addr,
    output logic              ld_state,
    output logic              rnd_en,
    output logic              mix_en,
    output logic              busy,
    output logic              abort
);

    localparam logic [ADDR_W-1:0] RK_NONE_A  = ADDR_W'(RK_NONE);
    localparam logic [ADDR_W-1:0] RK_FIRST_A = ADDR_W'(RK_FIRST);
    localparam logic [ADDR_W-1:0] RK_START_A = ADDR_W'(RK_FIRST + 1);
    localparam logic [ADDR_W-1:0] RK_LAST_A  = ADDR_W'(rk_last(NUM_ROUNDS));
    localparam logic [ADDR_W-1:0] RND_TERM_A = ADDR_W'(NUM_ROUNDS);

    state_t            state;
    logic [ADDR_W-1:0] rnd_cnt;
    logic              rnd_tc;
    logic              cnt_clr;
    logic              cnt_load;
    logic              cnt_inc;
    logic              accept;

    assign accept = din_valid & din_ready;

    // Counter holds the current middle-round key index; it is parked at 0
    // whenever the controller is not inside LOAD/ROUND.
    assign cnt_load = (state == ST_LOAD);
    assign cnt_inc  = (state == ST_ROUND) & key_loaded & ~rnd_tc;
    assign cnt_clr  = ~cnt_load & ~cnt_inc;

    aes_round_counter #(
        .W (ADDR_W)
    ) u_round_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (RK_START_A),
        .inc      (cnt_inc),
        .term_val (RND_TERM_A),
        .cnt      (rnd_cnt),
        .tc       (rnd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            abort <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!key_loaded) begin
                        state <= ST_IDLE;
                        abort <= 1'b1;
                    end else begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (!key_loaded) begin
                        state <= ST_IDLE;
                        abort <= 1'b1;
                    end else if (rnd_tc) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    if (!key_loaded) begin
                        state <= ST_IDLE;
                        abort <= 1'b1;
                    end else begin
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // A completed block is delivered even if the key store
                    // went away; accept already blocks a new one in that case.
                    if (dout_ready) begin
                        state <= accept ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        rk_addr    = RK_NONE_A;
        ld_state   = 1'b0;
        rnd_en     = 1'b0;
        mix_en     = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                din_ready = key_loaded;
            end
            ST_LOAD: begin
                rk_addr  = RK_FIRST_A;
                ld_state = 1'b1;
                busy     = 1'b1;
            end
            ST_ROUND: begin
                rk_addr = rnd_cnt;
                rnd_en  = 1'b1;
                mix_en  = 1'b1;
                busy    = 1'b1;
            end
            ST_FINAL: begin
                rk_addr = RK_LAST_A;
                rnd_en  = 1'b1;
                busy    = 1'b1;
            end
            ST_OUT: begin
                dout_valid = 1'b1;
                din_ready  = dout_ready & key_loaded;
            end
            default: begin
                din_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed scenarios followed by random
// traffic, all compared against a block-position reference model.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_loaded;
    logic          din_valid;
    logic          din_ready;
    logic          dout_valid;
    logic          dout_ready;
    logic [AW-1:0] rk_addr;
    logic          ld_state;
    logic          rnd_en;
    logic          mix_en;
    logic          busy;
    logic          abort;

    aes_round_ctrl #(
        .NUM_ROUNDS (NR),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_loaded (key_loaded),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rk_addr    (rk_addr),
        .ld_state   (ld_state),
        .rnd_en     (rnd_en),
        .mix_en     (mix_en),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pos = -1 idle, 1..NR+1 = cycles since the accepting
    // handshake while the block is being processed, NR+2 = result on output.
    int   pos  = -1;
    logic ab_m = 1'b0;

    logic [AW-1:0] s_rk;
    logic          s_dv;
    logic          s_dr;
    logic          s_busy;
    logic          s_ab;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int e_rk;
        e_rk = (pos >= 1 && pos <= NR + 1) ? pos : 0;
        cmp("rk_addr",    32'(rk_addr),    32'(e_rk));
        cmp("ld_state",   32'(ld_state),   32'(pos == 1));
        cmp("rnd_en",     32'(rnd_en),     32'(pos >= 2 && pos <= NR + 1));
        cmp("mix_en",     32'(mix_en),     32'(pos >= 2 && pos <= NR));
        cmp("busy",       32'(busy),       32'(pos >= 1 && pos <= NR + 1));
        cmp("dout_valid", 32'(dout_valid), 32'(pos == NR + 2));
        cmp("din_ready",  32'(din_ready),
            32'(key_loaded && (pos == -1 || (pos == NR + 2 && dout_ready))));
        cmp("abort",      32'(abort),      32'(ab_m));
    endtask

    task automatic model_step();
        if (!rst_n) begin
            pos  = -1;
            ab_m = 1'b0;
        end else begin
            ab_m = 1'b0;
            if (pos >= 1 && pos <= NR + 1) begin
                if (!key_loaded) begin
                    pos  = -1;
                    ab_m = 1'b1;
                end else begin
                    pos = pos + 1;
                end
            end else if (pos == -1) begin
                if (din_valid && key_loaded) pos = 1;
            end else if (pos == NR + 2) begin
                if (dout_ready) pos = (din_valid && key_loaded) ? 1 : -1;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model at the rising
    // edge, return 1 time unit later so the caller can drive new inputs.
    task automatic cycle();
        @(negedge clk);
        check_model();
        s_rk   = rk_addr;
        s_dv   = dout_valid;
        s_dr   = din_ready;
        s_busy = busy;
        s_ab   = abort;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int first_dv;
        int dv_idx[$];
        int activity;
        int found;

        rst_n      = 1'b0;
        key_loaded = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #2;
        cmp("reset_rk",   32'(rk_addr),    0);
        cmp("reset_busy", 32'(busy),       0);
        cmp("reset_dv",   32'(dout_valid), 0);
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // Single block, consumer stalled at the end.
        key_loaded = 1'b1;
        din_valid  = 1'b1;
        cycle();
        din_valid = 1'b0;
        first_dv  = -1;
        for (int i = 1; i <= NR + 2; i++) begin
            cycle();
            if (i <= NR + 1) cmp("seq_rk", 32'(s_rk), 32'(i));
            if (s_dv && first_dv < 0) first_dv = i;
        end
        cmp("first_dv", 32'(first_dv), 32'(NR + 2));

        // Output held while the consumer stalls, even with new input waiting.
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            cmp("hold_dv", 32'(s_dv), 1);
            cmp("hold_dr", 32'(s_dr), 0);
        end

        // Back-to-back blocks with an always-ready consumer.
        dout_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_dv) dv_idx.push_back(i);
        end
        cmp("b2b_pulses", 32'(dv_idx.size()), 3);
        if (dv_idx.size() >= 3) begin
            cmp("b2b_space1", 32'(dv_idx[1] - dv_idx[0]), 32'(NR + 2));
            cmp("b2b_space2", 32'(dv_idx[2] - dv_idx[1]), 32'(NR + 2));
        end
        din_valid = 1'b0;
        repeat (NR + 4) cycle();

        // Key store not loaded: nothing may start.
        key_loaded = 1'b0;
        din_valid  = 1'b1;
        activity   = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_busy || s_dv || s_dr) activity++;
        end
        cmp("noload_activity", 32'(activity), 0);

        // Key store lost while rk_addr = 6: abort, no result.
        key_loaded = 1'b1;
        cycle();
        din_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (pos == 6) found = 1;
        end
        cmp("reach_rk6", 32'(found), 1);
        key_loaded = 1'b0;
        cycle();
        key_loaded = 1'b1;
        cycle();
        cmp("abort_pulse", 32'(s_ab), 1);
        activity = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (s_dv || s_ab) activity++;
        end
        cmp("abort_no_dv", 32'(activity), 0);

        // Asynchronous reset in the middle of a block.
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (pos == 5) found = 1;
        end
        cmp("reach_rk5", 32'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst_rk",     32'(rk_addr),    0);
        cmp("arst_ld",     32'(ld_state),   0);
        cmp("arst_rnd",    32'(rnd_en),     0);
        cmp("arst_mix",    32'(mix_en),     0);
        cmp("arst_busy",   32'(busy),       0);
        cmp("arst_dv",     32'(dout_valid), 0);
        cmp("arst_abort",  32'(abort),      0);
        cmp("arst_dready", 32'(din_ready),  1);
        pos  = -1;
        ab_m = 1'b0;
        repeat (2) cycle();
        rst_n     = 1'b1;
        din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        first_dv  = -1;
        for (int i = 1; i <= NR + 3; i++) begin
            cycle();
            if (s_dv && first_dv < 0) first_dv = i;
        end
        cmp("restart_dv", 32'(first_dv), 32'(NR + 2));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            key_loaded = ($urandom_range(0, 39) != 0);
            din_valid  = $urandom_range(0, 1) == 1;
            dout_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
